alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 152 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-preparation stage ahead of the ALU: two-entry skid buffer (MAIN/SKID)
// that builds R2/R3 from register data, immediates and writeback forwarding.
module alu_operand_stage #(
  parameter int word_size = 32,
  parameter int addr_size = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [1:0]           in_aluop,
  input  logic [addr_size-1:0] in_rs_addr,
  input  logic [addr_size-1:0] in_rt_addr,
  input  logic [addr_size-1:0] in_rd_addr,
  input  logic [word_size-1:0] in_rs_data,
  input  logic [word_size-1:0] in_rt_data,
  input  logic [15:0]          in_imm,
  input  logic                 in_use_imm,
  input  logic                 in_sext,
  input  logic                 fwd_en,
  input  logic [addr_size-1:0] fwd_addr,
  input  logic [word_size-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word_size-1:0] alu_r2,
  output logic [word_size-1:0] alu_r3,
  output logic [1:0]           alu_aluop,
  output logic [3:0]           alu_opcode,
  output logic [addr_size-1:0] out_rd_addr
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [word_size-1:0] r2;
    logic [word_size-1:0] r3;
    logic [addr_size-1:0] rs_addr;
    logic [addr_size-1:0] rt_addr;
    logic [addr_size-1:0] rd_addr;
    logic                 r3_imm;
    logic [1:0]           aluop;
    logic [3:0]           opcode;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_e, main_fw, skid_fw;
  logic   in_fire, out_fire;
  logic   fwd_live;

  // Valid/ready: a transfer happens on a cycle where both valid and ready are
  // high at the rising edge; valid never depends combinationally on ready.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;
  assign fwd_live = fwd_en & (fwd_addr != '0);

  always_comb begin
    new_e         = '0;
    new_e.rs_addr = in_rs_addr;
    new_e.rt_addr = in_rt_addr;
    new_e.rd_addr = in_rd_addr;
    new_e.r3_imm  = in_use_imm;
    new_e.aluop   = in_aluop;
    new_e.opcode  = in_opcode;
    new_e.r2      = (fwd_live && fwd_addr == in_rs_addr) ? fwd_data : in_rs_data;
    if (in_use_imm)
      new_e.r3 = in_sext ? {{(word_size-16){in_imm[15]}}, in_imm}
                         : {{(word_size-16){1'b0}}, in_imm};
    else
      new_e.r3 = (fwd_live && fwd_addr == in_rt_addr) ? fwd_data : in_rt_data;
  end

  // Held entries keep tracking writebacks so they never go stale while stalled.
  always_comb begin
    main_fw = main_q;
    skid_fw = skid_q;
    if (fwd_live && state_q != EMPTY) begin
      if (main_q.rs_addr == fwd_addr) main_fw.r2 = fwd_data;
      if (!main_q.r3_imm && main_q.rt_addr == fwd_addr) main_fw.r3 = fwd_data;
    end
    if (fwd_live && state_q == TWO) begin
      if (skid_q.rs_addr == fwd_addr) skid_fw.r2 = fwd_data;
      if (!skid_q.r3_imm && skid_q.rt_addr == fwd_addr) skid_fw.r3 = fwd_data;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_fw;
    skid_d  = skid_fw;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = new_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = new_e;
        end else if (in_fire) begin
          skid_d  = new_e;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_d  = skid_fw;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
    // Flush from TWO leaves in_ready low for one extra cycle.
    if (flush) begin
      state_d    = EMPTY;
      main_d     = main_q;
      skid_d     = skid_q;
      in_ready_d = (state_q != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign alu_r2      = main_q.r2;
  assign alu_r3      = main_q.r3;
  assign alu_aluop   = main_q.aluop;
  assign alu_opcode  = main_q.opcode;
  assign out_rd_addr = main_q.rd_addr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [1:0]  in_aluop = '0;
  logic [4:0]  in_rs_addr = '0, in_rt_addr = '0, in_rd_addr = '0;
  logic [31:0] in_rs_data = '0, in_rt_data = '0;
  logic [15:0] in_imm = '0;
  logic        in_use_imm = 1'b0, in_sext = 1'b0;
  logic        fwd_en = 1'b0;
  logic [4:0]  fwd_addr = '0;
  logic [31:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_r2, alu_r3;
  logic [1:0]  alu_aluop;
  logic [3:0]  alu_opcode;
  logic [4:0]  out_rd_addr;

  alu_operand_stage #(.word_size(32), .addr_size(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_aluop(in_aluop),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_sext(in_sext),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_aluop(alu_aluop),
    .alu_opcode(alu_opcode), .out_rd_addr(out_rd_addr)
  );

  // clock block
  always #5 clk = ~clk;

  // reference model: ordered list of held instructions, head is what the ALU sees
  typedef struct {
    logic [31:0] r2;
    logic [31:0] r3;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    bit          imm;
    logic [1:0]  aluop;
    logic [3:0]  opcode;
  } ent_t;

  ent_t exp_q[$];
  bit   exp_rdy = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] pick(logic [4:0] a, logic [31:0] d);
    if (fwd_en && fwd_addr != 0 && fwd_addr == a) return fwd_data;
    return d;
  endfunction

  task automatic model_update();
    ent_t e;
    bit   take, give;
    if (rst) begin
      exp_q.delete();
      exp_rdy = 1'b0;
    end else if (flush) begin
      exp_rdy = (exp_q.size() != 2);
      exp_q.delete();
    end else begin
      take = in_valid && exp_rdy;
      give = (exp_q.size() > 0) && out_ready;
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        e.r2 = pick(e.rs, e.r2);
        if (!e.imm) e.r3 = pick(e.rt, e.r3);
        exp_q[i] = e;
      end
      if (give) void'(exp_q.pop_front());
      if (take) begin
        e.rs = in_rs_addr; e.rt = in_rt_addr; e.rd = in_rd_addr;
        e.imm = in_use_imm; e.aluop = in_aluop; e.opcode = in_opcode;
        e.r2 = pick(in_rs_addr, in_rs_data);
        if (in_use_imm) e.r3 = in_sext ? 32'(signed'(in_imm)) : {16'h0, in_imm};
        else            e.r3 = pick(in_rt_addr, in_rt_data);
        exp_q.push_back(e);
      end
      exp_rdy = (exp_q.size() != 2);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare against the model head
  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("alu_r2", alu_r2, exp_q[0].r2);
      chk("alu_r3", alu_r3, exp_q[0].r3);
      chk("alu_aluop", 32'(alu_aluop), 32'(exp_q[0].aluop));
      chk("alu_opcode", 32'(alu_opcode), 32'(exp_q[0].opcode));
      chk("out_rd_addr", 32'(out_rd_addr), 32'(exp_q[0].rd));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  // driver tasks
  task automatic drive_instr(input logic [4:0] rs, input logic [31:0] rsd,
                             input logic [4:0] rt, input logic [31:0] rtd,
                             input logic [4:0] rd, input logic [1:0] aluop,
                             input logic [3:0] opc);
    in_valid = 1'b1; in_rs_addr = rs; in_rs_data = rsd; in_rt_addr = rt;
    in_rt_data = rtd; in_rd_addr = rd; in_aluop = aluop; in_opcode = opc;
    in_use_imm = 1'b0; in_sext = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; fwd_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_r2", alu_r2, 32'd0);
    chk("rst_r3", alu_r3, 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single pass
    out_ready = 1'b1;
    drive_instr(5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 2'b00, 4'b0010);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_r2", alu_r2, 32'd5);
    chk("single_r3", alu_r3, 32'd7);
    chk("single_opcode", 32'(alu_opcode), 32'd2);

    // immediates
    in_imm = 16'h8001; in_use_imm = 1'b1; in_sext = 1'b1;
    step();
    chk("imm_sext", alu_r3, 32'hFFFF8001);
    in_sext = 1'b0;
    step();
    chk("imm_zext", alu_r3, 32'h00008001);
    drain();

    // backpressure A, B, C
    out_ready = 1'b0;
    drive_instr(5'd1, 32'd11, 5'd2, 32'd12, 5'd1, 2'b01, 4'd1); step();
    drive_instr(5'd1, 32'd21, 5'd2, 32'd22, 5'd2, 2'b01, 4'd2); step();
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    drive_instr(5'd1, 32'd31, 5'd2, 32'd32, 5'd3, 2'b01, 4'd3); step(); step();
    chk("bp_hold_a", 32'(out_rd_addr), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_then_b", 32'(out_rd_addr), 32'd2);
    step();
    chk("bp_then_c", 32'(out_rd_addr), 32'd3);
    chk("bp_c_r2", alu_r2, 32'd31);
    in_valid = 1'b0;
    step();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // forwarding at capture and while held
    out_ready = 1'b0;
    drive_instr(5'd6, 32'd1, 5'd6, 32'd10, 5'd4, 2'b10, 4'd5);
    fwd_en = 1'b1; fwd_addr = 5'd6; fwd_data = 32'd99;
    step();
    chk("fwd_capture", alu_r2, 32'd99);
    in_valid = 1'b0; fwd_data = 32'd42;
    step();
    chk("fwd_held", alu_r3, 32'd42);
    drain();
    out_ready = 1'b0;
    drive_instr(5'd0, 32'd5, 5'd0, 32'd8, 5'd4, 2'b10, 4'd5);
    fwd_en = 1'b1; fwd_addr = 5'd0; fwd_data = 32'd77;
    step();
    chk("fwd_r0_capture", alu_r2, 32'd5);
    in_valid = 1'b0;
    step();
    chk("fwd_r0_held", alu_r3, 32'd8);
    drain();

    // flush while TWO
    out_ready = 1'b0;
    drive_instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd7, 2'b00, 4'd0); step(); step();
    flush = 1'b1;
    step();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    idle();
    step();
    chk("flush_ready_back", 32'(in_ready), 32'd1);

    // reset while TWO
    drive_instr(5'd1, 32'd3, 5'd2, 32'd4, 5'd8, 2'b11, 4'd15); step(); step();
    rst = 1'b1;
    step();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_r2", alu_r2, 32'd0);
    chk("midrst_rd", 32'(out_rd_addr), 32'd0);
    idle();
    step();
    chk("midrst_ready_back", 32'(in_ready), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      in_valid   = $urandom_range(0, 1);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_rs_addr = 5'($urandom_range(0, 7));
      in_rt_addr = 5'($urandom_range(0, 7));
      in_rd_addr = 5'($urandom_range(0, 31));
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_imm     = 16'($urandom);
      in_use_imm = $urandom_range(0, 1);
      in_sext    = $urandom_range(0, 1);
      in_aluop   = 2'($urandom_range(0, 3));
      in_opcode  = 4'($urandom_range(0, 15));
      fwd_en     = $urandom_range(0, 1);
      fwd_addr   = 5'($urandom_range(0, 7));
      fwd_data   = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
